// File: rtl/id_ex_stage_if.sv
// ID/EX bus: decoded bundle from the decode stage, registered copy toward
// execute, and the stall controls returned to PC and IF/ID.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32
);
  // decode-side bundle
  logic                  id_reg_dst;
  logic                  id_branch_eq;
  logic                  id_branch_ne;
  logic                  id_mem_read;
  logic                  id_mem_to_reg;
  logic                  id_mem_write;
  logic                  id_alu_src;
  logic                  id_reg_write;
  logic [2:0]            id_alu_op;
  logic [DATA_WIDTH-1:0] id_read_data1;
  logic [DATA_WIDTH-1:0] id_read_data2;
  logic [DATA_WIDTH-1:0] id_imm_ext;
  logic [DATA_WIDTH-1:0] id_pc_plus4;
  logic [4:0]            id_rs;
  logic [4:0]            id_rt;
  logic [4:0]            id_rd;

  // execute-side registered bundle
  logic                  ex_reg_dst;
  logic                  ex_branch_eq;
  logic                  ex_branch_ne;
  logic                  ex_mem_read;
  logic                  ex_mem_to_reg;
  logic                  ex_mem_write;
  logic                  ex_alu_src;
  logic                  ex_reg_write;
  logic [2:0]            ex_alu_op;
  logic [DATA_WIDTH-1:0] ex_read_data1;
  logic [DATA_WIDTH-1:0] ex_read_data2;
  logic [DATA_WIDTH-1:0] ex_imm_ext;
  logic [DATA_WIDTH-1:0] ex_pc_plus4;
  logic [4:0]            ex_rs;
  logic [4:0]            ex_rt;
  logic [4:0]            ex_rd;

  // stall controls
  logic                  pc_write;
  logic                  if_id_write;

  modport master (
    output id_reg_dst, id_branch_eq, id_branch_ne, id_mem_read, id_mem_to_reg,
           id_mem_write, id_alu_src, id_reg_write, id_alu_op, id_read_data1,
           id_read_data2, id_imm_ext, id_pc_plus4, id_rs, id_rt, id_rd,
    input  ex_reg_dst, ex_branch_eq, ex_branch_ne, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op, ex_read_data1,
           ex_read_data2, ex_imm_ext, ex_pc_plus4, ex_rs, ex_rt, ex_rd,
           pc_write, if_id_write
  );

  modport slave (
    input  id_reg_dst, id_branch_eq, id_branch_ne, id_mem_read, id_mem_to_reg,
           id_mem_write, id_alu_src, id_reg_write, id_alu_op, id_read_data1,
           id_read_data2, id_imm_ext, id_pc_plus4, id_rs, id_rt, id_rd,
    output ex_reg_dst, ex_branch_eq, ex_branch_ne, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op, ex_read_data1,
           ex_read_data2, ex_imm_ext, ex_pc_plus4, ex_rs, ex_rt, ex_rd,
           pc_write, if_id_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on stall or flush, and a saturating stall-cycle counter.
module id_ex_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  id_ex_stage_if.slave               bus,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  logic hazard;
  logic bubble;

  // Load in EX whose destination is a source of the ID instruction.
  // Register 0 never carries a dependency; a flush squashes the ID
  // instruction anyway, so it must not stall.
  always_comb begin
    hazard = bus.ex_mem_read
           & (bus.ex_rt != 5'd0)
           & ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt))
           & ~flush;
    bubble = flush | hazard;
  end

  assign bus.pc_write    = ~hazard;
  assign bus.if_id_write = ~hazard;

  // Control bundle: zeroed on a bubble so nothing downstream has side effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_reg_dst    <= 1'b0;
      bus.ex_branch_eq  <= 1'b0;
      bus.ex_branch_ne  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_alu_op     <= 3'b000;
    end else if (bubble) begin
      bus.ex_reg_dst    <= 1'b0;
      bus.ex_branch_eq  <= 1'b0;
      bus.ex_branch_ne  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_alu_op     <= 3'b000;
    end else begin
      bus.ex_reg_dst    <= bus.id_reg_dst;
      bus.ex_branch_eq  <= bus.id_branch_eq;
      bus.ex_branch_ne  <= bus.id_branch_ne;
      bus.ex_mem_read   <= bus.id_mem_read;
      bus.ex_mem_to_reg <= bus.id_mem_to_reg;
      bus.ex_mem_write  <= bus.id_mem_write;
      bus.ex_alu_src    <= bus.id_alu_src;
      bus.ex_reg_write  <= bus.id_reg_write;
      bus.ex_alu_op     <= bus.id_alu_op;
    end
  end

  // Data, index and PC fields always follow ID; under a bubble they are
  // ignored because every control bit is zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_read_data1 <= '0;
      bus.ex_read_data2 <= '0;
      bus.ex_imm_ext    <= '0;
      bus.ex_pc_plus4   <= '0;
      bus.ex_rs         <= 5'd0;
      bus.ex_rt         <= 5'd0;
      bus.ex_rd         <= 5'd0;
    end else begin
      bus.ex_read_data1 <= bus.id_read_data1;
      bus.ex_read_data2 <= bus.id_read_data2;
      bus.ex_imm_ext    <= bus.id_imm_ext;
      bus.ex_pc_plus4   <= bus.id_pc_plus4;
      bus.ex_rs         <= bus.id_rs;
      bus.ex_rt         <= bus.id_rt;
      bus.ex_rd         <= bus.id_rd;
    end
  end

  // Stall-cycle counter: counts hazard edges, sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (hazard && (stall_count != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic,
// checked against a bundle-level reference model.
module tb_id_ex_stage;
  localparam int DW = 32;

  typedef struct packed {
    logic          reg_dst;
    logic          branch_eq;
    logic          branch_ne;
    logic          mem_read;
    logic          mem_to_reg;
    logic          mem_write;
    logic          alu_src;
    logic          reg_write;
    logic [2:0]    alu_op;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
  } bundle_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [15:0] stall_count;
  logic [1:0]  stall_count_s;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_WIDTH(DW)) bus ();
  id_ex_stage_if #(.DATA_WIDTH(DW)) bus_s ();

  id_ex_stage #(.DATA_WIDTH(DW), .STALL_CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus), .stall_count(stall_count)
  );

  id_ex_stage #(.DATA_WIDTH(DW), .STALL_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_s), .stall_count(stall_count_s)
  );

  // The narrow-counter instance sees the same decode traffic.
  assign bus_s.id_reg_dst    = bus.id_reg_dst;
  assign bus_s.id_branch_eq  = bus.id_branch_eq;
  assign bus_s.id_branch_ne  = bus.id_branch_ne;
  assign bus_s.id_mem_read   = bus.id_mem_read;
  assign bus_s.id_mem_to_reg = bus.id_mem_to_reg;
  assign bus_s.id_mem_write  = bus.id_mem_write;
  assign bus_s.id_alu_src    = bus.id_alu_src;
  assign bus_s.id_reg_write  = bus.id_reg_write;
  assign bus_s.id_alu_op     = bus.id_alu_op;
  assign bus_s.id_read_data1 = bus.id_read_data1;
  assign bus_s.id_read_data2 = bus.id_read_data2;
  assign bus_s.id_imm_ext    = bus.id_imm_ext;
  assign bus_s.id_pc_plus4   = bus.id_pc_plus4;
  assign bus_s.id_rs         = bus.id_rs;
  assign bus_s.id_rt         = bus.id_rt;
  assign bus_s.id_rd         = bus.id_rd;

  int checks = 0;
  int passes = 0;

  // reference model state
  bundle_t     m_ex;
  int unsigned m_cnt;
  int unsigned m_cnt_s;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bundle_t observe();
    bundle_t o;
    o.reg_dst    = bus.ex_reg_dst;
    o.branch_eq  = bus.ex_branch_eq;
    o.branch_ne  = bus.ex_branch_ne;
    o.mem_read   = bus.ex_mem_read;
    o.mem_to_reg = bus.ex_mem_to_reg;
    o.mem_write  = bus.ex_mem_write;
    o.alu_src    = bus.ex_alu_src;
    o.reg_write  = bus.ex_reg_write;
    o.alu_op     = bus.ex_alu_op;
    o.rd1        = bus.ex_read_data1;
    o.rd2        = bus.ex_read_data2;
    o.imm        = bus.ex_imm_ext;
    o.pc         = bus.ex_pc_plus4;
    o.rs         = bus.ex_rs;
    o.rt         = bus.ex_rt;
    o.rd         = bus.ex_rd;
    return o;
  endfunction

  task automatic drive(input bundle_t b, input logic fl);
    flush             = fl;
    bus.id_reg_dst    = b.reg_dst;
    bus.id_branch_eq  = b.branch_eq;
    bus.id_branch_ne  = b.branch_ne;
    bus.id_mem_read   = b.mem_read;
    bus.id_mem_to_reg = b.mem_to_reg;
    bus.id_mem_write  = b.mem_write;
    bus.id_alu_src    = b.alu_src;
    bus.id_reg_write  = b.reg_write;
    bus.id_alu_op     = b.alu_op;
    bus.id_read_data1 = b.rd1;
    bus.id_read_data2 = b.rd2;
    bus.id_imm_ext    = b.imm;
    bus.id_pc_plus4   = b.pc;
    bus.id_rs         = b.rs;
    bus.id_rt         = b.rt;
    bus.id_rd         = b.rd;
  endtask

  // A bubble keeps the payload but drops every control bit.
  function automatic bundle_t as_bubble(input bundle_t b);
    bundle_t o = b;
    o.reg_dst = 0; o.branch_eq = 0; o.branch_ne = 0; o.mem_read = 0;
    o.mem_to_reg = 0; o.mem_write = 0; o.alu_src = 0; o.reg_write = 0;
    o.alu_op = 3'b000;
    return o;
  endfunction

  // Load-use rule evaluated on the model's view of EX.
  function automatic logic model_stall(input bundle_t ex, input bundle_t id, input logic fl);
    return ex.mem_read && (ex.rt != 0) && (ex.rt == id.rs || ex.rt == id.rt) && !fl;
  endfunction

  // One pipeline cycle: present ID at negedge, check stall controls, clock,
  // then check the EX bundle and counters.
  task automatic step(input bundle_t b, input logic fl, input string tag, output logic pw);
    logic h;
    @(negedge clk);
    drive(b, fl);
    #1;
    h  = model_stall(m_ex, b, fl);
    pw = bus.pc_write;
    check({tag, "/pc_write"}, bus.pc_write, !h);
    check({tag, "/if_id_write"}, bus.if_id_write, !h);
    @(posedge clk);
    if (h) begin
      if (m_cnt < 16'hFFFF) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
    m_ex = (fl || h) ? as_bubble(b) : b;
    #1;
    check({tag, "/ex_bundle"}, observe(), m_ex);
    check({tag, "/stall_count"}, stall_count, m_cnt);
    check({tag, "/stall_count_w2"}, stall_count_s, m_cnt_s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_ex = '0; m_cnt = 0; m_cnt_s = 0;
    check("reset/ex_bundle", observe(), '0);
    check("reset/stall_count", stall_count, 0);
    check("reset/pc_write", bus.pc_write, 1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t addi, lw, rtype, sw, rb;
    logic pw;
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    reset = 1'b0;
    drive('0, 1'b0);
    do_reset();

    // ADDI passes straight through
    addi = '0; addi.alu_src = 1; addi.reg_write = 1; addi.alu_op = 3'b110;
    addi.rs = 2; addi.rt = 3; addi.imm = 32'h5; addi.rd1 = 32'h1111; addi.pc = 32'h104;
    drive(addi, 1'b0);
    #1;
    check("addi/pre_edge_zero", observe(), '0);
    check("addi/pre_edge_pc_write", bus.pc_write, 1);
    step(addi, 1'b0, "addi", pw);
    check("addi/alu_op", bus.ex_alu_op, 3'b110);

    // load-use stall lasts one cycle
    lw = '0; lw.mem_read = 1; lw.mem_to_reg = 1; lw.alu_src = 1; lw.reg_write = 1;
    lw.rs = 1; lw.rt = 8; lw.imm = 32'h10; lw.pc = 32'h108;
    rtype = '0; rtype.reg_dst = 1; rtype.reg_write = 1; rtype.alu_op = 3'b010;
    rtype.rs = 8; rtype.rt = 9; rtype.rd = 10; rtype.rd1 = 32'hAAAA; rtype.pc = 32'h10C;
    step(lw, 1'b0, "lu_lw", pw);
    step(rtype, 1'b0, "lu_stall", pw);
    check("lu_stall/pc_write_low", pw, 0);
    check("lu_stall/mem_read_bubble", bus.ex_reg_write, 0);
    check("lu_stall/count", stall_count, 16'd1);
    step(rtype, 1'b0, "lu_release", pw);
    check("lu_release/pc_write_high", pw, 1);
    check("lu_release/rd", bus.ex_rd, 5'd10);

    // rt = 0 never stalls
    lw.rt = 0;
    rtype.rs = 0; rtype.rt = 0;
    step(lw, 1'b0, "r0_lw", pw);
    step(rtype, 1'b0, "r0_id", pw);
    check("r0/pc_write", pw, 1);
    check("r0/count", stall_count, 16'd1);

    // flush beats hazard
    lw.rt = 8;
    rtype.rs = 8;
    step(lw, 1'b0, "fl_lw", pw);
    step(rtype, 1'b1, "fl_hz", pw);
    check("fl_hz/pc_write", pw, 1);
    check("fl_hz/reg_write", bus.ex_reg_write, 0);
    check("fl_hz/count", stall_count, 16'd1);

    // SW squashed by flush, then passes
    sw = '0; sw.mem_write = 1; sw.alu_src = 1; sw.alu_op = 3'b001; sw.rs = 4; sw.rt = 5;
    step(sw, 1'b1, "sw_flush", pw);
    check("sw_flush/mem_write", bus.ex_mem_write, 0);
    check("sw_flush/alu_op", bus.ex_alu_op, 3'b000);
    step(sw, 1'b0, "sw_pass", pw);
    check("sw_pass/mem_write", bus.ex_mem_write, 1);
    check("sw_pass/alu_op", bus.ex_alu_op, 3'b001);

    // 2-bit counter saturates over five load-use pairs
    do_reset();
    rtype.rs = 8; rtype.rt = 9;
    for (int i = 0; i < 5; i++) begin
      step(lw, 1'b0, "sat_lw", pw);
      step(rtype, 1'b0, "sat_stall", pw);
      check("sat/count_w2", stall_count_s, sat_exp[i]);
      step(rtype, 1'b0, "sat_release", pw);
    end

    // reset in the middle of a stall
    step(lw, 1'b0, "mid_lw", pw);
    @(negedge clk);
    drive(rtype, 1'b0);
    #1;
    check("mid/pc_write_low", bus.pc_write, 0);
    reset = 1'b0;
    #1;
    m_ex = '0; m_cnt = 0; m_cnt_s = 0;
    check("mid/mem_read_clear", bus.ex_mem_read, 0);
    check("mid/count_clear", stall_count, 16'd0);
    check("mid/count_w2_clear", stall_count_s, 2'd0);
    check("mid/pc_write_reset", bus.pc_write, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid/pc_write_after", bus.pc_write, 1);

    // random traffic biased toward dependencies
    for (int i = 0; i < 300; i++) begin
      rb = '0;
      rb.reg_dst = 1'($urandom); rb.branch_eq = 1'($urandom); rb.branch_ne = 1'($urandom);
      rb.mem_read = ($urandom_range(0, 2) == 0); rb.mem_to_reg = 1'($urandom);
      rb.mem_write = 1'($urandom); rb.alu_src = 1'($urandom); rb.reg_write = 1'($urandom);
      rb.alu_op = 3'($urandom);
      rb.rd1 = $urandom; rb.rd2 = $urandom; rb.imm = $urandom; rb.pc = $urandom;
      rb.rs = 5'($urandom_range(0, 7)); rb.rt = 5'($urandom_range(0, 7)); rb.rd = 5'($urandom);
      if ($urandom_range(0, 2) == 0) rb.rs = m_ex.rt;
      step(rb, ($urandom_range(0, 7) == 0), "rand", pw);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
